mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences every data-memory access made by the MEM stage against a variable-latency data memory using a req/ack handshake. On a slow access it stalls the upstream pipeline and drives mem_flush so the MEM/WB register takes a bubble each wait cycle. It detects misaligned accesses, bus errors and access timeouts, raises a held exception to the exception unit, and keeps a saturating count of stall cycles.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without ack before a timeout exception (1..65535)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
ex_mem_read  input  1  EX/MEM holds a load
ex_mem_write  input  1  EX/MEM holds a store
ex_mem_addr  input  32  access byte address
ex_mem_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
dmem_req  output  1  request to data memory
dmem_we  output  1  write enable to data memory
dmem_addr  output  32  address to data memory
dmem_ack  input  1  memory completes the access this cycle
dmem_err  input  1  memory reports a bus error this cycle
pipe_stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM
mem_flush  output  1  to MEM/WB: load a bubble this edge
exc_valid  output  1  exception pending, held until acknowledged
exc_code  output  2  01 misaligned, 10 bus error, 11 timeout
exc_addr  output  32  faulting address
exc_ack  input  1  exception unit accepts; upstream flushes EX/MEM at the same edge
stall_cycles  output  CNT_W  saturating count of cycles with pipe_stall=1

Behaviour:
- reset (async, active-low, reset=0): state IDLE. All outputs 0, including wait counter, stall_cycles, exc_code and exc_addr. Asserting reset mid-WAIT drops dmem_req immediately.
- Pending access: pend = ex_mem_read | ex_mem_write. If both are 1, the access is a write (dmem_we=1).
- Alignment: byte accesses are always aligned. Half requires addr[0]=0. Word and size 11 require addr[1:0]=0.
- States: IDLE, WAIT, EXC. Outputs are Mealy on dmem_ack and dmem_err.
- IDLE, pend=0: all outputs are idle.
- IDLE, pend=1, misaligned:
  - No request is issued.
  - pipe_stall=1, mem_flush=1.
  - Latch exc_code=01 and exc_addr=ex_mem_addr, then go to EXC.
- IDLE, pend=1, aligned:
  - Drive dmem_req=1, dmem_addr=ex_mem_addr and dmem_we combinationally.
  - Latch addr and we into hold registers.
- IDLE request outcomes (checked in priority order):
  - dmem_err: pipe_stall=1, mem_flush=1, latch code 10, go to EXC.
  - dmem_ack: zero-wait access. pipe_stall=0, mem_flush=0, stay in IDLE.
  - otherwise: pipe_stall=1, mem_flush=1, clear the wait counter, go to WAIT.
- WAIT:
  - dmem_req=1; dmem_addr and dmem_we come from the hold registers, not from the inputs.
  - Ack and error checks, in priority order:
    - dmem_err: pipe_stall=1, mem_flush=1, latch code 10, go to EXC.
    - dmem_ack: pipe_stall=0, mem_flush=0 in that same cycle, so MEM/WB captures the real result. Go to IDLE. The next instruction is seen in IDLE one cycle later.
  - Otherwise pipe_stall=1, mem_flush=1 and the wait counter increments.
  - Timeout: when the counter reaches TIMEOUT_CYCLES-1 with no ack:
    - dmem_req drops at the next edge.
    - Latch code 11 and exc_addr from the hold address.
    - Go to EXC.
- EXC:
  - exc_valid=1, pipe_stall=1, mem_flush=1, dmem_req=0.
  - On exc_ack: go to IDLE. exc_valid is 0 from the next cycle; exc_code and exc_addr keep their last values.
  - dmem_ack or dmem_err arriving in EXC are ignored.
- Single outstanding request. dmem_req is never dropped before ack, err or timeout.
- Latency: a zero-wait access completes with no stall cycles. An N-wait access stalls exactly N cycles and inserts N bubbles into MEM/WB.
- stall_cycles increments by 1 on every edge where pipe_stall=1 and saturates at all-ones.

Decomposition:
- Shared package (pipe_defs):
  - state encoding: IDLE=2'd0, WAIT=2'd1, EXC=2'd2
  - exc codes: EXC_MISALIGN=2'b01, EXC_BUSERR=2'b10, EXC_TIMEOUT=2'b11
  - size codes: SZ_BYTE, SZ_HALF, SZ_WORD
- One sub-module, mem_align_chk: combinational alignment check (addr[1:0], size -> misaligned). Reused later by the fetch path.

Test Plan:
- Zero-wait load: read=1, addr=0x100, size=10, ack in the same cycle -> dmem_req for 1 cycle, pipe_stall=0, mem_flush=0, stall_cycles stays 0.
- 3-wait store: write=1, addr=0x204, ack 3 cycles after request:
  - pipe_stall=1 and mem_flush=1 for exactly 3 cycles, both 0 in the ack cycle.
  - dmem_we=1 and dmem_addr=0x204 held throughout.
  - stall_cycles=3.
- Misaligned half: read=1, addr=0x101, size=01 -> no dmem_req, exc_valid=1, exc_code=01, exc_addr=0x101. exc_valid stays 1 until exc_ack is pulsed, then 0; state returns to IDLE.
- Timeout with TIMEOUT_CYCLES=4, never ack -> dmem_req drops after the 4th wait cycle, exc_code=11, exc_addr equals the request address.
- Bus error in the 2nd wait cycle -> exc_code=10, dmem_req=0 the next cycle. Both read=1 and write=1 -> dmem_we=1.
- Reset mid-WAIT: reset=0 asynchronously -> dmem_req, pipe_stall, mem_flush and stall_cycles are 0 immediately. After release with pend=1, a fresh request is issued.

Source files
------------

// File: rtl/pipe_defs.sv
// pipe_defs: shared FSM state, exception-code and access-size encodings for the MEM stage
package pipe_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EXC  = 2'd2
   } state_t;

   localparam logic [1:0] EXC_MISALIGN = 2'b01;
   localparam logic [1:0] EXC_BUSERR   = 2'b10;
   localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: MEM-stage, data-memory and exception-unit signals around the access controller
interface mem_access_ctrl_if #(parameter int unsigned CNT_W = 16);

   logic              ex_mem_read;
   logic              ex_mem_write;
   logic [31:0]       ex_mem_addr;
   logic [1:0]        ex_mem_size;
   logic              dmem_req;
   logic              dmem_we;
   logic [31:0]       dmem_addr;
   logic              dmem_ack;
   logic              dmem_err;
   logic              pipe_stall;
   logic              mem_flush;
   logic              exc_valid;
   logic [1:0]        exc_code;
   logic [31:0]       exc_addr;
   logic              exc_ack;
   logic [CNT_W-1:0]  stall_cycles;

   modport master (
      input  ex_mem_read, ex_mem_write, ex_mem_addr, ex_mem_size,
      input  dmem_ack, dmem_err, exc_ack,
      output dmem_req, dmem_we, dmem_addr,
      output pipe_stall, mem_flush,
      output exc_valid, exc_code, exc_addr, stall_cycles
   );

   modport slave (
      output ex_mem_read, ex_mem_write, ex_mem_addr, ex_mem_size,
      output dmem_ack, dmem_err, exc_ack,
      input  dmem_req, dmem_we, dmem_addr,
      input  pipe_stall, mem_flush,
      input  exc_valid, exc_code, exc_addr, stall_cycles
   );

endinterface

// File: rtl/mem_align_chk.sv
// mem_align_chk: flags an access whose byte address is not aligned to its size (size 11 acts as word)
module mem_align_chk
   import pipe_defs::*;
(
   input  logic [1:0] i_addr_lo,
   input  logic [1:0] i_size,
   output logic       o_misaligned
);

   assign o_misaligned = (i_size == SZ_BYTE) ? 1'b0 :
                         (i_size == SZ_HALF) ? i_addr_lo[0] : |i_addr_lo;

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage data accesses over req/ack, stalls on wait states, raises held exceptions
module mem_access_ctrl
   import pipe_defs::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 16
)(
   input  logic              clk,
   input  logic              reset,
   mem_access_ctrl_if.master bus
);

   localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t            r_state;
   state_t            w_next;
   logic [15:0]       r_wcnt;
   logic [15:0]       w_wcnt_nxt;
   logic [31:0]       r_hold_addr;
   logic              r_hold_we;
   logic              w_hold_ld;
   logic [1:0]        r_exc_code;
   logic [1:0]        w_exc_code_nxt;
   logic [31:0]       r_exc_addr;
   logic [31:0]       w_exc_addr_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_pend;
   logic              w_we_in;
   logic              w_mis;
   logic              w_req;
   logic              w_we;
   logic [31:0]       w_addr;
   logic              w_stall;

   assign w_pend  = bus.ex_mem_read | bus.ex_mem_write;
   assign w_we_in = bus.ex_mem_write;

   mem_align_chk u_align (
      .i_addr_lo    (bus.ex_mem_addr[1:0]),
      .i_size       (bus.ex_mem_size),
      .o_misaligned (w_mis)
   );

   // State, wait counter, hold and exception registers; reset returns to IDLE with everything cleared
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_wcnt      <= '0;
         r_hold_addr <= '0;
         r_hold_we   <= 1'b0;
         r_exc_code  <= '0;
         r_exc_addr  <= '0;
      end else begin
         r_state    <= w_next;
         r_wcnt     <= w_wcnt_nxt;
         r_exc_code <= w_exc_code_nxt;
         r_exc_addr <= w_exc_addr_nxt;
         if (w_hold_ld) begin
            r_hold_addr <= bus.ex_mem_addr;
            r_hold_we   <= w_we_in;
         end
      end
   end

   // Stall-cycle counter: one per stalled edge, sticks at all-ones
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_stall_cnt <= '0;
      else if (w_stall && r_stall_cnt != '1)
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   // Next state and Mealy outputs; ack/err only matter while a request is on the bus
   always_comb begin
      w_next         = r_state;
      w_wcnt_nxt     = r_wcnt;
      w_hold_ld      = 1'b0;
      w_exc_code_nxt = r_exc_code;
      w_exc_addr_nxt = r_exc_addr;
      w_req          = 1'b0;
      w_we           = 1'b0;
      w_addr         = '0;
      w_stall        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pend && w_mis) begin
               w_stall        = 1'b1;
               w_exc_code_nxt = EXC_MISALIGN;
               w_exc_addr_nxt = bus.ex_mem_addr;
               w_next         = EXC;
            end else if (w_pend) begin
               w_req     = 1'b1;
               w_we      = w_we_in;
               w_addr    = bus.ex_mem_addr;
               w_hold_ld = 1'b1;
               if (bus.dmem_err) begin
                  w_stall        = 1'b1;
                  w_exc_code_nxt = EXC_BUSERR;
                  w_exc_addr_nxt = bus.ex_mem_addr;
                  w_next         = EXC;
               end else if (!bus.dmem_ack) begin
                  w_stall    = 1'b1;
                  w_wcnt_nxt = '0;
                  w_next     = WAIT;
               end
            end
         end
         WAIT: begin
            w_req  = 1'b1;
            w_we   = r_hold_we;
            w_addr = r_hold_addr;
            if (bus.dmem_err) begin
               w_stall        = 1'b1;
               w_exc_code_nxt = EXC_BUSERR;
               w_exc_addr_nxt = r_hold_addr;
               w_next         = EXC;
            end else if (bus.dmem_ack) begin
               w_next = IDLE;
            end else begin
               w_stall = 1'b1;
               if (r_wcnt == LP_TO_LAST) begin
                  w_exc_code_nxt = EXC_TIMEOUT;
                  w_exc_addr_nxt = r_hold_addr;
                  w_next         = EXC;
               end else begin
                  w_wcnt_nxt = r_wcnt + 16'd1;
               end
            end
         end
         EXC: begin
            w_stall = 1'b1;
            w_next  = bus.exc_ack ? IDLE : EXC;
         end
         default: w_next = IDLE;
      endcase
   end

   assign bus.dmem_req     = reset & w_req;
   assign bus.dmem_we      = reset & w_we;
   assign bus.dmem_addr    = reset ? w_addr : 32'd0;
   assign bus.pipe_stall   = reset & w_stall;
   assign bus.mem_flush    = reset & w_stall;
   assign bus.exc_valid    = (r_state == EXC);
   assign bus.exc_code     = r_exc_code;
   assign bus.exc_addr     = r_exc_addr;
   assign bus.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors checked every cycle against a transaction-level model plus pinned literals
module tb_mem_access_ctrl;

   localparam int unsigned T_O = 4;
   localparam int unsigned CW  = 5;
   localparam int          SAT = (1 << CW) - 1;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   tag;

   mem_access_ctrl_if #(.CNT_W(CW)) bus ();

   mem_access_ctrl #(.TIMEOUT_CYCLES(T_O), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: is a request outstanding, how many wait cycles elapsed, is an exception pending
   logic        m_busy, n_busy;
   int          m_waits, n_waits;
   logic [31:0] m_hold_addr, n_hold_addr;
   logic        m_hold_we, n_hold_we;
   logic        m_exc, n_exc;
   logic [1:0]  m_code, n_code;
   logic [31:0] m_eaddr, n_eaddr;
   int          m_stalls, n_stalls;

   logic        e_req, e_we, e_stall, pend, mis;
   logic [31:0] e_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 0; m_waits <= 0; m_hold_addr <= 0; m_hold_we <= 0;
         m_exc <= 0; m_code <= 0; m_eaddr <= 0; m_stalls <= 0;
      end else begin
         m_busy <= n_busy; m_waits <= n_waits; m_hold_addr <= n_hold_addr; m_hold_we <= n_hold_we;
         m_exc <= n_exc; m_code <= n_code; m_eaddr <= n_eaddr; m_stalls <= n_stalls;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_req", {31'd0, bus.dmem_req}, 0);
         chk("rst_stall", {31'd0, bus.pipe_stall}, 0);
         chk("rst_flush", {31'd0, bus.mem_flush}, 0);
         chk("rst_exc_valid", {31'd0, bus.exc_valid}, 0);
         chk("rst_exc_code", {30'd0, bus.exc_code}, 0);
         chk("rst_exc_addr", bus.exc_addr, 0);
         chk("rst_stall_cycles", 32'(bus.stall_cycles), 0);
      end else begin
         pend = bus.ex_mem_read | bus.ex_mem_write;
         mis  = (bus.ex_mem_size == 2'b00) ? 1'b0 :
                (bus.ex_mem_size == 2'b01) ? bus.ex_mem_addr[0] : (bus.ex_mem_addr[1:0] != 2'b00);
         e_req = 0; e_we = 0; e_addr = 0; e_stall = 0;
         n_busy = m_busy; n_waits = m_waits; n_hold_addr = m_hold_addr; n_hold_we = m_hold_we;
         n_exc = m_exc; n_code = m_code; n_eaddr = m_eaddr;
         if (m_exc) begin
            e_stall = 1;
            if (bus.exc_ack) n_exc = 0;
         end else if (m_busy) begin
            e_req = 1; e_addr = m_hold_addr; e_we = m_hold_we;
            if (bus.dmem_err) begin
               e_stall = 1; n_busy = 0; n_exc = 1; n_code = 2'b10; n_eaddr = m_hold_addr;
            end else if (bus.dmem_ack) begin
               n_busy = 0;
            end else begin
               e_stall = 1;
               if (m_waits + 1 == int'(T_O)) begin
                  n_busy = 0; n_exc = 1; n_code = 2'b11; n_eaddr = m_hold_addr;
               end else begin
                  n_waits = m_waits + 1;
               end
            end
         end else if (pend && mis) begin
            e_stall = 1; n_exc = 1; n_code = 2'b01; n_eaddr = bus.ex_mem_addr;
         end else if (pend) begin
            e_req = 1; e_addr = bus.ex_mem_addr; e_we = bus.ex_mem_write;
            n_hold_addr = bus.ex_mem_addr; n_hold_we = bus.ex_mem_write;
            if (bus.dmem_err) begin
               e_stall = 1; n_exc = 1; n_code = 2'b10; n_eaddr = bus.ex_mem_addr;
            end else if (!bus.dmem_ack) begin
               e_stall = 1; n_busy = 1; n_waits = 0;
            end
         end
         n_stalls = (e_stall && m_stalls < SAT) ? m_stalls + 1 : m_stalls;
         chk("req", {31'd0, bus.dmem_req}, {31'd0, e_req});
         chk("stall", {31'd0, bus.pipe_stall}, {31'd0, e_stall});
         chk("flush", {31'd0, bus.mem_flush}, {31'd0, e_stall});
         chk("exc_valid", {31'd0, bus.exc_valid}, {31'd0, m_exc});
         chk("exc_code", {30'd0, bus.exc_code}, {30'd0, m_code});
         chk("exc_addr", bus.exc_addr, m_eaddr);
         chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
         if (e_req) begin
            chk("we", {31'd0, bus.dmem_we}, {31'd0, e_we});
            chk("addr", bus.dmem_addr, e_addr);
         end
         case (tag)
            1: begin chk("L_zw_req", {31'd0, bus.dmem_req}, 1); chk("L_zw_stall", {31'd0, bus.pipe_stall}, 0); chk("L_zw_flush", {31'd0, bus.mem_flush}, 0); end
            2: chk("L_zw_cnt", 32'(bus.stall_cycles), 0);
            3: begin chk("L_st_we", {31'd0, bus.dmem_we}, 1); chk("L_st_addr", bus.dmem_addr, 32'h204); chk("L_st_stall", {31'd0, bus.pipe_stall}, 1); end
            4: begin chk("L_st_ack_stall", {31'd0, bus.pipe_stall}, 0); chk("L_st_hold_addr", bus.dmem_addr, 32'h204); chk("L_st_hold_we", {31'd0, bus.dmem_we}, 1); end
            5: chk("L_st_cnt", 32'(bus.stall_cycles), 3);
            6: begin chk("L_mis_valid", {31'd0, bus.exc_valid}, 1); chk("L_mis_code", {30'd0, bus.exc_code}, 1); chk("L_mis_addr", bus.exc_addr, 32'h101); chk("L_mis_req", {31'd0, bus.dmem_req}, 0); end
            7: begin chk("L_mis_clr", {31'd0, bus.exc_valid}, 0); chk("L_mis_keep", {30'd0, bus.exc_code}, 1); chk("L_mis_cnt", 32'(bus.stall_cycles), 8); end
            8: begin chk("L_to_req", {31'd0, bus.dmem_req}, 0); chk("L_to_code", {30'd0, bus.exc_code}, 3); chk("L_to_addr", bus.exc_addr, 32'h300); end
            9: chk("L_to_w4_req", {31'd0, bus.dmem_req}, 1);
            10: chk("L_be_we", {31'd0, bus.dmem_we}, 1);
            11: begin chk("L_be_req", {31'd0, bus.dmem_req}, 0); chk("L_be_code", {30'd0, bus.exc_code}, 2); chk("L_be_addr", bus.exc_addr, 32'h400); end
            12: begin chk("L_sat_cnt", 32'(bus.stall_cycles), 31); chk("L_sat_code", {30'd0, bus.exc_code}, 1); chk("L_sat_addr", bus.exc_addr, 32'h402); end
            13: begin chk("L_rst_req", {31'd0, bus.dmem_req}, 1); chk("L_rst_addr", bus.dmem_addr, 32'h600); chk("L_rst_cnt", 32'(bus.stall_cycles), 0); chk("L_rst_stall", {31'd0, bus.pipe_stall}, 0); end
            default: ;
         endcase
      end
   end

   task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                      input logic ack, input logic err, input logic eack, input int t);
      bus.ex_mem_read  = rd;
      bus.ex_mem_write = wr;
      bus.ex_mem_addr  = a;
      bus.ex_mem_size  = sz;
      bus.dmem_ack     = ack;
      bus.dmem_err     = err;
      bus.exc_ack      = eack;
      tag              = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 32'h100, 2, 0, 0, 0, 0);
      reset = 1'b1;
      // zero-wait load
      cyc(1, 0, 32'h100, 2, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 2);
      // 3-wait store; EX/MEM inputs change to show the hold registers drive the bus
      cyc(0, 1, 32'h204, 2, 0, 0, 0, 3);
      cyc(0, 1, 32'h999, 2, 0, 0, 0, 0);
      cyc(0, 1, 32'h999, 2, 0, 0, 0, 0);
      cyc(0, 1, 32'h999, 2, 1, 0, 0, 4);
      cyc(0, 0, 0, 0, 0, 0, 0, 5);
      // misaligned half; ack/err in EXC are ignored
      cyc(1, 0, 32'h101, 1, 0, 0, 0, 0);
      cyc(1, 0, 32'h101, 1, 1, 0, 0, 0);
      cyc(1, 0, 32'h101, 1, 0, 1, 0, 0);
      cyc(1, 0, 32'h101, 1, 0, 0, 0, 6);
      cyc(1, 0, 32'h101, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 7);
      // aligned half, odd byte store, size-11 bus error on the request cycle
      cyc(1, 0, 32'h102, 1, 1, 0, 0, 0);
      cyc(0, 1, 32'h103, 0, 1, 0, 0, 0);
      cyc(1, 0, 32'h010, 3, 0, 1, 0, 0);
      cyc(1, 0, 32'h010, 3, 0, 0, 1, 0);
      // timeout after four wait cycles
      cyc(1, 0, 32'h300, 2, 0, 0, 0, 0);
      cyc(1, 0, 32'h300, 2, 0, 0, 0, 0);
      cyc(1, 0, 32'h300, 2, 0, 0, 0, 0);
      cyc(1, 0, 32'h300, 2, 0, 0, 0, 0);
      cyc(1, 0, 32'h300, 2, 0, 0, 0, 9);
      cyc(1, 0, 32'h300, 2, 1, 1, 0, 8);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      // bus error in the second wait cycle, read+write acts as write
      cyc(1, 1, 32'h400, 0, 0, 0, 0, 10);
      cyc(1, 1, 32'h400, 0, 0, 0, 0, 0);
      cyc(1, 1, 32'h400, 0, 0, 1, 0, 0);
      cyc(1, 1, 32'h400, 0, 0, 0, 0, 11);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      // long-held misaligned word exception drives the stall counter into saturation
      for (int i = 0; i < 13; i++) cyc(1, 0, 32'h402, 3, 0, 0, 0, 0);
      cyc(1, 0, 32'h402, 3, 0, 0, 0, 12);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      // one-wait load
      cyc(1, 0, 32'h700, 2, 0, 0, 0, 0);
      cyc(1, 0, 32'h700, 2, 1, 0, 0, 0);
      // reset asserted in the middle of a WAIT cycle, then a fresh request
      cyc(1, 0, 32'h500, 2, 0, 0, 0, 0);
      cyc(1, 0, 32'h500, 2, 0, 0, 0, 0);
      reset = 1'b0;
      cyc(1, 0, 32'h500, 2, 0, 0, 0, 0);
      cyc(1, 0, 32'h500, 2, 0, 0, 0, 0);
      reset = 1'b1;
      cyc(1, 0, 32'h600, 2, 1, 0, 0, 13);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
